// File: rtl/bus_mem_responder_if.sv
// Bus bundle between the CPU data port and the memory responder.
// Rd_Count/Wr_Count exist only when ACCESS_COUNT_EN is defined.
interface bus_mem_responder_if;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        Data_Valid;
    logic        Addr_Err;
`ifdef ACCESS_COUNT_EN
    logic [31:0] Rd_Count;
    logic [31:0] Wr_Count;

    modport master (
        output CS, WR_RD, ADDR, Data_BUS_WRITE,
        input  Data_BUS_READ, Data_Valid, Addr_Err, Rd_Count, Wr_Count
    );

    modport slave (
        input  CS, WR_RD, ADDR, Data_BUS_WRITE,
        output Data_BUS_READ, Data_Valid, Addr_Err, Rd_Count, Wr_Count
    );
`else
    modport master (
        output CS, WR_RD, ADDR, Data_BUS_WRITE,
        input  Data_BUS_READ, Data_Valid, Addr_Err
    );

    modport slave (
        input  CS, WR_RD, ADDR, Data_BUS_WRITE,
        output Data_BUS_READ, Data_Valid, Addr_Err
    );
`endif
endinterface

// File: rtl/bus_mem_responder.sv
// Word-addressed data memory on the CPU bus with a fixed read latency.
// Optional feature macro: ACCESS_COUNT_EN adds completed-read / accepted-write counters.
module bus_mem_responder #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input logic               Clk,
    input logic               Reset,
    bus_mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic              hit;
    logic              aligned;
    logic              accessOk;
    logic              wrAccept;
    logic              rdIssue;
    logic              reject;
    logic [ADDR_W-1:0] wordIdx;

    logic [READ_LATENCY-1:0] pipeValidQ, pipeValidD;
    logic [31:0]             pipeDataQ [READ_LATENCY];
    logic [31:0]             readDataQ, readDataD;
    logic                    dataValidQ, dataValidD;
    logic                    addrErrQ, addrErrD;
    logic                    readDone;
`ifdef ACCESS_COUNT_EN
    logic [31:0]             rdCountQ, rdCountD;
    logic [31:0]             wrCountQ, wrCountD;
`endif

    assign hit      = (bus.ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign aligned  = (bus.ADDR[1:0] == 2'b00);
    assign wordIdx  = bus.ADDR[ADDR_W+1:2];
    // Accesses seen while Reset is high are dropped entirely.
    assign accessOk = bus.CS & hit & aligned & ~Reset;
    assign wrAccept = accessOk & bus.WR_RD;
    assign rdIssue  = accessOk & ~bus.WR_RD;
    assign reject   = bus.CS & ~(hit & aligned) & ~Reset;
    assign readDone = pipeValidQ[READ_LATENCY-1];

    // RAM and read-data stages carry no reset so the array maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (wrAccept) begin
            mem[wordIdx] <= bus.Data_BUS_WRITE;
        end
        if (rdIssue) begin
            pipeDataQ[0] <= mem[wordIdx];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeDataQ[i] <= pipeDataQ[i-1];
        end
    end

    always_comb begin
        pipeValidD    = '0;
        pipeValidD[0] = rdIssue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeValidD[i] = pipeValidQ[i-1];
        end
        readDataD  = readDone ? pipeDataQ[READ_LATENCY-1] : readDataQ;
        dataValidD = readDone;
        addrErrD   = reject;
`ifdef ACCESS_COUNT_EN
        rdCountD = rdCountQ + {31'b0, readDone};
        wrCountD = wrCountQ + {31'b0, wrAccept};
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pipeValidQ <= '0;
            readDataQ  <= '0;
            dataValidQ <= 1'b0;
            addrErrQ   <= 1'b0;
`ifdef ACCESS_COUNT_EN
            rdCountQ   <= '0;
            wrCountQ   <= '0;
`endif
        end else begin
            pipeValidQ <= pipeValidD;
            readDataQ  <= readDataD;
            dataValidQ <= dataValidD;
            addrErrQ   <= addrErrD;
`ifdef ACCESS_COUNT_EN
            rdCountQ   <= rdCountD;
            wrCountQ   <= wrCountD;
`endif
        end
    end

    assign bus.Data_BUS_READ = readDataQ;
    assign bus.Data_Valid    = dataValidQ;
    assign bus.Addr_Err      = addrErrQ;
`ifdef ACCESS_COUNT_EN
    assign bus.Rd_Count      = rdCountQ;
    assign bus.Wr_Count      = wrCountQ;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: three responders (read latency 1, 2, 3) share one stimulus stream
// so every memory holds the same contents and only the output timing differs.
module tb_bus_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cs;
    logic        wrRd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    bus_mem_responder_if bus1 ();
    bus_mem_responder_if bus2 ();
    bus_mem_responder_if bus3 ();

    assign bus1.CS = cs;  assign bus1.WR_RD = wrRd;  assign bus1.ADDR = addr;  assign bus1.Data_BUS_WRITE = wdata;
    assign bus2.CS = cs;  assign bus2.WR_RD = wrRd;  assign bus2.ADDR = addr;  assign bus2.Data_BUS_WRITE = wdata;
    assign bus3.CS = cs;  assign bus3.WR_RD = wrRd;  assign bus3.ADDR = addr;  assign bus3.Data_BUS_WRITE = wdata;

    bus_mem_responder #(.ADDR_W(10), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u1 (.Clk(Clk), .Reset(Reset), .bus(bus1));
    bus_mem_responder #(.ADDR_W(10), .BASE_ADDR(32'h0), .READ_LATENCY(2)) u2 (.Clk(Clk), .Reset(Reset), .bus(bus2));
    bus_mem_responder #(.ADDR_W(10), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u3 (.Clk(Clk), .Reset(Reset), .bus(bus3));

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle, let the edge happen, and settle just after it.
    task automatic applyStimulus(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        cs    = c;
        wrRd  = w;
        addr  = a;
        wdata = d;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("init_data", bus1.Data_BUS_READ, 32'h0);
        checkOutput("init_valid", {31'b0, bus1.Data_Valid}, 32'h0);
        checkOutput("init_err", {31'b0, bus1.Addr_Err}, 32'h0);
        Reset = 1'b0;

        // Write then read next cycle, latency 1/2/3 arrival times.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        checkOutput("t2_wr_valid", {31'b0, bus1.Data_Valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        checkOutput("t2_issue_valid", {31'b0, bus1.Data_Valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t2_l1_valid", {31'b0, bus1.Data_Valid}, 32'h1);
        checkOutput("t2_l1_data", bus1.Data_BUS_READ, 32'hDEADBEEF);
        checkOutput("t2_l2_early", {31'b0, bus2.Data_Valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t2_l1_pulse_end", {31'b0, bus1.Data_Valid}, 32'h0);
        checkOutput("t2_l1_hold", bus1.Data_BUS_READ, 32'hDEADBEEF);
        checkOutput("t2_l2_valid", {31'b0, bus2.Data_Valid}, 32'h1);
        checkOutput("t2_l2_data", bus2.Data_BUS_READ, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t2_l3_valid", {31'b0, bus3.Data_Valid}, 32'h1);
        checkOutput("t2_l3_data", bus3.Data_BUS_READ, 32'hDEADBEEF);

        // Back-to-back reads of 1, 2, 3.
        applyStimulus(1'b1, 1'b1, 32'h0, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h4, 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h8, 32'd3);
        for (int k = 0; k < 7; k++) begin
            if (k < 3) applyStimulus(1'b1, 1'b0, 32'(4 * k), 32'h0);
            else       applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("t3_l3_valid_%0d", k), {31'b0, bus3.Data_Valid}, (k >= 3 && k <= 5) ? 32'h1 : 32'h0);
            if (k >= 3 && k <= 5) checkOutput($sformatf("t3_l3_data_%0d", k), bus3.Data_BUS_READ, 32'(k - 2));
            checkOutput($sformatf("t3_l1_valid_%0d", k), {31'b0, bus1.Data_Valid}, (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
            if (k >= 1 && k <= 3) checkOutput($sformatf("t3_l1_data_%0d", k), bus1.Data_BUS_READ, 32'(k));
        end

        // Read then write same word: in-flight read keeps old data.
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hAAAA0000);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h00005555);
        checkOutput("t4_l1_old_valid", {31'b0, bus1.Data_Valid}, 32'h1);
        checkOutput("t4_l1_old_data", bus1.Data_BUS_READ, 32'hAAAA0000);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        checkOutput("t4_l1_gap", {31'b0, bus1.Data_Valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t4_l1_new_data", bus1.Data_BUS_READ, 32'h00005555);
        checkOutput("t4_l3_old_data", bus3.Data_BUS_READ, 32'hAAAA0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t4_l3_new_valid", {31'b0, bus3.Data_Valid}, 32'h1);
        checkOutput("t4_l3_new_data", bus3.Data_BUS_READ, 32'h00005555);

        // Misaligned and out-of-window writes are rejected; both would alias word 0.
        applyStimulus(1'b1, 1'b1, 32'h2, 32'hFFFFFFFF);
        checkOutput("t5_err_misaligned", {31'b0, bus1.Addr_Err}, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h0001_0000, 32'hFFFFFFFF);
        checkOutput("t5_err_window", {31'b0, bus1.Addr_Err}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_err_clear", {31'b0, bus1.Addr_Err}, 32'h0);
`ifdef ACCESS_COUNT_EN
        checkOutput("t5_wr_count", bus1.Wr_Count, 32'd6);
        checkOutput("t5_rd_count", bus1.Rd_Count, 32'd6);
`endif
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_ram_intact", bus1.Data_BUS_READ, 32'd1);
        checkOutput("t5_no_err_on_read", {31'b0, bus1.Addr_Err}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset after activity: outputs clear, accesses during reset ignored, RAM kept.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 32'h3, 32'h12345678);
        checkOutput("t1_l1_data", bus1.Data_BUS_READ, 32'h0);
        checkOutput("t1_l3_data", bus3.Data_BUS_READ, 32'h0);
        checkOutput("t1_l1_valid", {31'b0, bus1.Data_Valid}, 32'h0);
        checkOutput("t1_err", {31'b0, bus1.Addr_Err}, 32'h0);
`ifdef ACCESS_COUNT_EN
        checkOutput("t1_wr_count", bus1.Wr_Count, 32'd0);
        checkOutput("t1_rd_count", bus1.Rd_Count, 32'd0);
`endif
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_l2_flushed", {31'b0, bus2.Data_Valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_retained_valid", {31'b0, bus1.Data_Valid}, 32'h1);
        checkOutput("t1_retained_data", bus1.Data_BUS_READ, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_l2_retained", bus2.Data_BUS_READ, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset one edge after a latency-2 read issue: that read never completes.
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("t6_l2_valid_%0d", k), {31'b0, bus2.Data_Valid}, 32'h0);
            checkOutput($sformatf("t6_l2_data_%0d", k), bus2.Data_BUS_READ, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
Memory-side responder for the CPU data bus. It sits on the other end of CS / WR_RD / ADDR / Data_BUS_WRITE and drives Data_BUS_READ. It decodes the address window, services word writes into an internal RAM, and returns read data after a fixed, parameterised latency. It is the synthesizable data memory for CPU system simulation and FPGA bring-up.

Parameters:
ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words
BASE_ADDR, 32'h0000_0000, byte base of the decoded window; must be aligned to 4*2**ADDR_W
READ_LATENCY, 1, edges from read issue to Data_Valid; legal range 1..4

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
CS  input  1  bus cycle request, sampled every rising edge
WR_RD  input  1  1 = write, 0 = read; qualified by CS
ADDR  input  32  byte address from the CPU
Data_BUS_WRITE  input  32  write data; qualified by CS & WR_RD
Data_BUS_READ  output  32  read data; holds the last completed read
Data_Valid  output  1  one-cycle pulse when Data_BUS_READ has just been updated
Addr_Err  output  1  one-cycle pulse on a rejected access
Rd_Count  output  32  completed-read count (present only with ACCESS_COUNT_EN)
Wr_Count  output  32  accepted-write count (present only with ACCESS_COUNT_EN)

Behaviour:
- Reset (synchronous, Reset=1 at an edge):
  - Data_BUS_READ=0, Data_Valid=0, Addr_Err=0.
  - Read pipeline is flushed and counters are cleared.
  - RAM contents are NOT cleared.
  - Accesses presented while Reset=1 are ignored.
- Decode:
  - hit = (ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - aligned = (ADDR[1:0] == 2'b00).
  - Word index = ADDR[ADDR_W+1:2].
- Write: at an edge with CS=1, WR_RD=1, hit and aligned, RAM[index] <= Data_BUS_WRITE. Zero-latency accept; no acknowledge.
- Read issue: at an edge with CS=1, WR_RD=0, hit and aligned, RAM[index] is sampled into pipeline stage 1. The read returns the value as of that edge.
- Read completion:
  - The sampled word shifts through READ_LATENCY stages.
  - When it leaves the last stage, Data_BUS_READ is loaded and Data_Valid=1 for exactly one cycle.
  - The result is visible READ_LATENCY cycles after the issue edge.
- Back-to-back reads: one read may issue per cycle. Results emerge in order, one per cycle, with Data_Valid held high across consecutive completions.
- Write then read, same address, next cycle: the read returns the new data.
- Read then write, same address, next cycle: the in-flight read returns the old data.
- Rejected access (CS=1 and (!hit or !aligned)):
  - No RAM write, no pipeline entry.
  - Addr_Err=1 on the following cycle, for one cycle.
  - Consecutive rejected accesses hold Addr_Err high.
- CS=0: no operation. WR_RD, ADDR and Data_BUS_WRITE are don't-care. Pipeline stages still advance.
- Reset mid-read: in-flight reads are discarded; no Data_Valid is produced for them after reset.
- Counters wrap modulo 2**32.

Optional Feature:
ACCESS_COUNT_EN
- Defined:
  - Rd_Count and Wr_Count ports exist.
  - Rd_Count increments on each Data_Valid pulse.
  - Wr_Count increments on each accepted write.
  - Rejected accesses are not counted.
  - Both counters reset to 0.
- Undefined: the ports and counter registers are absent; all other behaviour is identical.

Test Plan:
1. Reset=1 for 2 cycles after arbitrary bus activity -> Data_BUS_READ=0, Data_Valid=0, Addr_Err=0, counters=0. A read of an address written before reset still returns its old data.
2. READ_LATENCY=1: write 32'hDEADBEEF to ADDR=0x10, then read 0x10 on the next cycle -> Data_BUS_READ=32'hDEADBEEF with Data_Valid pulsing exactly 1 cycle after the read edge.
3. READ_LATENCY=3: issue reads of 0x0, 0x4, 0x8 on consecutive cycles, preloaded with 1, 2, 3 -> Data_Valid high for 3 consecutive cycles starting 3 cycles after the first issue, with data 1, 2, 3 in order.
4. Read 0x20 (holding 32'hAAAA0000), then write 32'h5555 to 0x20 on the next cycle -> the read returns 32'hAAAA0000; a subsequent read returns 32'h5555.
5. Write to ADDR=0x2 (misaligned) and to 0x0001_0000 with ADDR_W=10 (out of window) -> Addr_Err pulses once per access; RAM is unchanged; Wr_Count stays 0 with ACCESS_COUNT_EN.
6. READ_LATENCY=2: issue a read, assert Reset on the next edge -> no Data_Valid is ever produced for that read; Data_BUS_READ=0.
